// File: rtl/lu_solver_ram_arbiter.sv
// Two-requester round-robin arbiter in front of the solver's single-port RAM.
// It grants in the same cycle, supports a bounded lock, and steers 1-cycle read data back to the issuer.
module lu_solver_ram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_r;
  logic [CNT_W-1:0] lock_cnt_r;
  logic             rv_r;
  logic             rid_r;

  logic             req0_s;
  logic             req1_s;
  logic             locked_s;
  logic             lock_id_s;
  logic             gnt_v_s;
  logic             gnt_id_s;
  logic             gnt_wr_s;
  logic             gnt_lock_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic             hold_lock_s;

  // Grant selection: an active lock owns the RAM, otherwise round-robin on last_r
  always_comb begin
    req0_s    = m0_read | m0_write;
    req1_s    = m1_read | m1_write;
    lock_id_s = (state_r == ST_LOCK1);
    locked_s  = 1'b0;
    gnt_v_s   = 1'b0;
    gnt_id_s  = 1'b0;
    // A lock whose owner is idle with lock dropped no longer blocks the other side
    case (state_r)
      ST_LOCK0: locked_s = req0_s | m0_lock;
      ST_LOCK1: locked_s = req1_s | m1_lock;
      default:  locked_s = 1'b0;
    endcase
    if (!reset_n) begin
      gnt_v_s  = 1'b0;
      gnt_id_s = 1'b0;
    end else if (locked_s) begin
      gnt_id_s = lock_id_s;
      gnt_v_s  = lock_id_s ? req1_s : req0_s;
    end else if (req0_s && req1_s) begin
      gnt_v_s  = 1'b1;
      gnt_id_s = ~last_r;
    end else if (req0_s || req1_s) begin
      gnt_v_s  = 1'b1;
      gnt_id_s = req1_s;
    end else begin
      gnt_v_s  = 1'b0;
      gnt_id_s = 1'b0;
    end
    gnt_wr_s    = gnt_id_s ? m1_write : m0_write;
    gnt_lock_s  = gnt_id_s ? m1_lock : m0_lock;
    next_cnt_s  = locked_s ? (lock_cnt_r + ONE_CNT) : ONE_CNT;
    hold_lock_s = gnt_lock_s & (next_cnt_s < MAX_CNT);
  end

  // Arbitration state, lock counter and read-return tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_RR;
      last_r     <= 1'b1;
      lock_cnt_r <= '0;
      rv_r       <= 1'b0;
      rid_r      <= 1'b0;
    end else begin
      rv_r  <= gnt_v_s & ~gnt_wr_s;
      rid_r <= gnt_id_s;
      if (gnt_v_s) begin
        last_r <= gnt_id_s;
        if (hold_lock_s) begin
          state_r    <= gnt_id_s ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_r <= next_cnt_s;
        end else begin
          state_r    <= ST_RR;
          lock_cnt_r <= '0;
        end
      end else if (!locked_s) begin
        state_r    <= ST_RR;
        lock_cnt_r <= '0;
      end else begin
        state_r    <= state_r;
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

  assign ram_clken        = reset_n;
  assign ram_chipselect   = gnt_v_s;
  assign ram_write        = gnt_v_s & gnt_wr_s;
  assign ram_address      = (gnt_v_s && gnt_id_s) ? m1_address    : m0_address;
  assign ram_byteenable   = (gnt_v_s && gnt_id_s) ? m1_byteenable : m0_byteenable;
  assign ram_writedata    = (gnt_v_s && gnt_id_s) ? m1_writedata  : m0_writedata;

  assign m0_waitrequest   = ~reset_n | (req0_s & ~(gnt_v_s & ~gnt_id_s));
  assign m1_waitrequest   = ~reset_n | (req1_s & ~(gnt_v_s & gnt_id_s));
  assign m0_readdatavalid = rv_r & ~rid_r;
  assign m1_readdatavalid = rv_r & rid_r;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_lu_solver_ram_arbiter.sv
// Scoreboard bench for lu_solver_ram_arbiter: a behavioural RAM behind the DUT,
// a reference memory and a queue of expected read returns.
module tb_lu_solver_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  logic        load_en;
  logic [12:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] mem [0:8191];
  logic [31:0] ref_mem [0:8191];

  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int obs_rdv0 = 0;
  int obs_rdv1 = 0;

  always #5 clk = ~clk;

  lu_solver_ram_arbiter #(.ADDR_W(13), .DATA_W(32), .BE_W(4), .MAX_LOCK(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // Behavioural single-port RAM with a 1-cycle registered read and a bench preload port
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic l);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d; m0_lock = l;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic l);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d; m1_lock = l;
  endtask

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
  endtask

  task automatic record(input logic id, input logic w, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      sb.push_back('{cyc: cyc, id: id, data: ref_mem[a]});
    end
  endtask

  // One bus cycle: ew0/ew1 are the expected waitrequests for the stimulus now applied
  task automatic tick(input logic ew0, input logic ew1);
    logic g0, g1, exp_v0, exp_v1;
    logic [31:0] exp_d;
    sb_t e;
    @(negedge clk);
    g0 = (m0_read | m0_write) & ~ew0;
    g1 = (m1_read | m1_write) & ~ew1;
    check("wait0", 32'(m0_waitrequest), 32'(ew0));
    check("wait1", 32'(m1_waitrequest), 32'(ew1));
    check("chipsel", 32'(ram_chipselect), 32'(g0 | g1));
    check("clken", 32'(ram_clken), 32'(reset_n));
    if (g0) begin
      check("addr_m0", 32'(ram_address), 32'(m0_address));
      check("wr_m0", 32'(ram_write), 32'(m0_write));
    end else if (g1) begin
      check("addr_m1", 32'(ram_address), 32'(m1_address));
      check("wr_m1", 32'(ram_write), 32'(m1_write));
    end else begin
      check("wr_idle", 32'(ram_write), 32'd0);
    end
    exp_v0 = 1'b0; exp_v1 = 1'b0; exp_d = 32'd0;
    if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
      e = sb.pop_front();
      exp_v0 = ~e.id; exp_v1 = e.id; exp_d = e.data;
    end
    check("rdv0", 32'(m0_readdatavalid), 32'(exp_v0));
    check("rdv1", 32'(m1_readdatavalid), 32'(exp_v1));
    if (exp_v0) check("rdata0", m0_readdata, exp_d);
    if (exp_v1) check("rdata1", m1_readdata, exp_d);
    obs_rdv0 += int'(m0_readdatavalid);
    obs_rdv1 += int'(m1_readdatavalid);
    if (g0) record(1'b0, m0_write, m0_address, m0_byteenable, m0_writedata);
    if (g1) record(1'b1, m1_write, m1_address, m1_byteenable, m1_writedata);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0;
    load_en = 1'b0; load_addr = 13'd0; load_data = 32'd0;
    set_m0(1'b0, 1'b0, 13'd0, 4'hF, 32'd0, 1'b0);
    set_m1(1'b0, 1'b0, 13'd0, 4'hF, 32'd0, 1'b0);
    @(posedge clk); #1;
    preload(13'h0005, 32'hDEADBEEF);
    preload(13'h0007, 32'h0BADF00D);
    preload(13'h1FFF, 32'hAAAAAAAA);
    load_en = 1'b0;
    tick(1'b1, 1'b1);
    reset_n = 1'b1;

    // Single m0 read with zero arbitration latency
    set_m0(1'b1, 1'b0, 13'h0005, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);

    // m1 read leaves last=m1 so the contention burst starts with m0
    set_m1(1'b1, 1'b0, 13'h0007, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    obs_rdv0 = 0; obs_rdv1 = 0;
    set_m0(1'b1, 1'b0, 13'h0005, 4'hF, 32'd0, 1'b0);
    set_m1(1'b1, 1'b0, 13'h1FFF, 4'hF, 32'd0, 1'b0);
    for (int c = 0; c < 8; c++) tick(c[0], ~c[0]);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("rdv0_count", 32'(obs_rdv0), 32'd4);
    check("rdv1_count", 32'(obs_rdv1), 32'd4);

    // Partial-byte write then read-after-write from the other master
    set_m1(1'b0, 1'b1, 13'h1FFF, 4'h3, 32'h12345678, 1'b0);
    tick(1'b0, 1'b0);
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    set_m0(1'b1, 1'b0, 13'h1FFF, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("be_merge", m0_readdata, 32'hAAAA5678);

    // m1 locks for 20 transfers against a requesting m0; lock breaks after 16
    set_m0(1'b1, 1'b0, 13'h0005, 4'hF, 32'd0, 1'b0);
    set_m1(1'b1, 1'b0, 13'h0007, 4'hF, 32'd0, 1'b1);
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m1_lock = (i < 3);
      tick(1'b0, 1'b0);
    end
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);

    // m0 holds an idle lock for 3 cycles; m1 is granted when the lock drops
    set_m0(1'b1, 1'b0, 13'h0005, 4'hF, 32'd0, 1'b1);
    tick(1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b1);
    set_m1(1'b1, 1'b0, 13'h0007, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    m0_lock = 1'b0;
    tick(1'b0, 1'b0);
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);

    // read and write both high is a write
    set_m0(1'b1, 1'b1, 13'h0009, 4'hF, 32'hCAFEF00D, 1'b0);
    tick(1'b0, 1'b0);
    set_m0(1'b1, 1'b0, 13'h0009, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);

    // Reset right after a granted read: the return must be dropped
    set_m0(1'b1, 1'b0, 13'h0005, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    reset_n = 1'b0;
    sb.delete();
    set_m1(1'b1, 1'b0, 13'h0007, 4'hF, 32'd0, 1'b0);
    tick(1'b1, 1'b1);
    reset_n = 1'b1;
    tick(1'b0, 1'b1);
    set_m0(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    set_m1(1'b0, 1'b0, 13'h0000, 4'hF, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lu_solver_ram_arbiter.md
# lu_solver_ram_arbiter

Two-requester arbiter that shares the solver's single-port 8192 x 32 on-chip RAM between the host-side Avalon-MM path (m0) and the LU elimination datapath (m1). It grants at most one transfer per cycle using round-robin, supports a bounded lock for atomic row sequences, and steers the RAM's 1-cycle read data back to the issuing requester with `readdatavalid`. It sits between both masters and the RAM's chipselect/write/address/byteenable/writedata/readdata pins.

## Interface
- `ADDR_W`, 13: word address width (8192 words)
- `DATA_W`, 32: data width
- `BE_W`, 4: byteenable width (DATA_W/8)
- `MAX_LOCK`, 16: maximum consecutive granted transfers held under lock (>=1)
- One clock, `clk`; reset `reset_n` is asynchronous and active-low.
- `clk`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `mN_address`  in  ADDR_W  word address (N = 0, 1)
- `mN_byteenable`  in  BE_W  write byte lanes
- `mN_read`, `mN_write`  in  1  request strobes; both high = protocol error, treated as write
- `mN_writedata`  in  DATA_W  write data
- `mN_lock`  in  1  request to keep grant after this transfer
- `mN_waitrequest`  out  1  stall; requester holds all inputs while high
- `mN_readdata`  out  DATA_W  read data, qualified by readdatavalid
- `mN_readdatavalid`  out  1  one-cycle pulse with read data
- `ram_address`  out  ADDR_W, `ram_byteenable`  out  BE_W, `ram_writedata`  out  DATA_W
- `ram_chipselect`, `ram_write`, `ram_clken`  out  1  RAM controls; `ram_clken` tied 1 outside reset
- `ram_readdata`  in  DATA_W  RAM output, valid 1 cycle after read address presented

## Operation
- req_N = mN_read | mN_write. Grant is combinational from req_0, req_1, state and `last` (registered last-granted index).
- State RR: one requester → grant it; both → grant !last. On any grant, last ← granted index.
- RR → LOCK_N when N is granted with mN_lock=1; lock_cnt ← 1.
- LOCK_N: only N may be granted; other requester waits. On each granted N transfer with lock=1, lock_cnt+1. Exit to RR when: N granted with mN_lock=0; or N idle with mN_lock=0; or lock_cnt reaches MAX_LOCK (that transfer completes, then RR with last=N, so the other side wins next contention).
- N idle with mN_lock=1 in LOCK_N: lock held, no grant, lock_cnt unchanged.
- Granted cycle: ram_chipselect=1, ram_write=mN_write, address/byteenable/writedata muxed from N; mN_waitrequest=0. Ungranted requesting master: waitrequest=1. Non-requesting master: waitrequest=0 (don't care).
- No grant: ram_chipselect=0, ram_write=0, ram mux holds m0 values.
- Read return: registered rv (valid) and rid (index) capture granted reads; next cycle m[rid]_readdatavalid=1, both mN_readdata = ram_readdata.
- Writes produce no response. Write at T then read same address at T+1 (either master) returns new data.

## Timing
- Reset (reset_n=0, async): state=RR, last=1 (m0 wins first contention), lock_cnt=0, rv=0; outputs: both waitrequest=1, readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0.
- Grant and RAM command in same cycle T (zero arbitration latency); read data at T+1; throughput 1 transfer/cycle.
- Alternating contention: grants m0,m1,m0,... each cycle, no bubbles.
- Back-to-back reads by the same master: readdatavalid asserted on consecutive cycles.
- Reset mid-read: pending readdatavalid discarded, not emitted after release.

## Test plan
- After reset, m0 read addr 0x0005 (RAM preloaded 0xDEADBEEF) -> waitrequest 0 at T, m0_readdatavalid=1 with 0xDEADBEEF at T+1, m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 8 cycles -> grants alternate m0,m1,... starting m0; each readdatavalid pulses exactly 4 times on its own port.
- m1 writes 0x12345678 to 0x1FFF with byteenable 0x3, next cycle m0 reads 0x1FFF (prior 0xAAAAAAAA) -> m0 gets 0xAAAA5678.
- m1 holds lock=1 for 20 transfers while m0 requests, MAX_LOCK=16 -> m1 granted 16 consecutive, then m0 granted, m0_waitrequest=1 during all 16.
- m0 locks, idles 3 cycles with lock=1, then lock=0 -> m1 blocked those 3 cycles, granted the cycle m0 lock drops.
- reset_n asserted the cycle after a granted read -> no readdatavalid emitted; after release both waitrequest follow rules, m0 wins first contention.
